gcd_controller: RTL and testbench

- Control FSM for the GCD datapath: issues the load, select and output-load strobes the datapath consumes, and reacts to its x_lt_y / x_neq_y compare flags.
- Runs repeated-subtraction GCD on the operands x_i / y_i presented to the datapath.
- Provides a go/done handshake to the enclosing top level.
- Bounds iterations so that a zero operand cannot hang the system.

---
 rtl/gcd_controller.sv | 108 ++++++++++
 tb/tb_gcd_controller.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/gcd_controller.sv
// Control FSM for the repeated-subtraction GCD datapath: drives the load/select
// strobes, runs the go/done handshake, and aborts with err after MAX_ITER subtractions.
module gcd_controller #(
  parameter int unsigned ITER_W   = 8,
  parameter int unsigned MAX_ITER = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              go,
  input  logic              x_lt_y,
  input  logic              x_neq_y,
  output logic              x_ld,
  output logic              y_ld,
  output logic              x_sel,
  output logic              y_sel,
  output logic              d_o_ld,
  output logic              enable,
  output logic              done,
  output logic              err,
  output logic [ITER_W-1:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_CMP  = 3'd2,
    S_SUBX = 3'd3,
    S_SUBY = 3'd4,
    S_OUT  = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  state_t            state, state_nxt;
  logic [ITER_W-1:0] iter_nxt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      iter_cnt <= '0;
    end else begin
      state    <= state_nxt;
      iter_cnt <= iter_nxt;
    end
  end

  // Limit test sits ahead of the subtract choice so a zero operand ends in ERR.
  always_comb begin
    state_nxt = state;
    iter_nxt  = iter_cnt;
    case (state)
      S_IDLE: if (go) state_nxt = S_LOAD;
      S_LOAD: begin
        iter_nxt  = '0;
        state_nxt = S_CMP;
      end
      S_CMP: begin
        if (!x_neq_y)                           state_nxt = S_OUT;
        else if (iter_cnt == ITER_W'(MAX_ITER)) state_nxt = S_ERR;
        else if (x_lt_y)                        state_nxt = S_SUBY;
        else                                    state_nxt = S_SUBX;
      end
      S_SUBX, S_SUBY: begin
        iter_nxt  = iter_cnt + 1'b1;
        state_nxt = S_CMP;
      end
      S_OUT:         state_nxt = S_DONE;
      S_DONE, S_ERR: if (!go) state_nxt = S_IDLE;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    x_ld   = 1'b0;
    y_ld   = 1'b0;
    x_sel  = 1'b0;
    y_sel  = 1'b0;
    d_o_ld = 1'b0;
    enable = 1'b0;
    done   = 1'b0;
    err    = 1'b0;
    case (state)
      S_LOAD: begin
        x_ld = 1'b1;
        y_ld = 1'b1;
      end
      S_SUBX: begin
        x_ld  = 1'b1;
        x_sel = 1'b1;
      end
      S_SUBY: begin
        y_ld  = 1'b1;
        y_sel = 1'b1;
      end
      S_OUT: d_o_ld = 1'b1;
      S_DONE: begin
        done   = 1'b1;
        enable = 1'b1;
      end
      S_ERR: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_gcd_controller.sv
// Directed bench for gcd_controller: two instances (default limit and MAX_ITER=4),
// each driving a small behavioural GCD datapath.
module tb_gcd_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic       go0, go1;
  logic [7:0] x_i, y_i;

  logic x_ld0, y_ld0, x_sel0, y_sel0, d_o_ld0, enable0, done0, err0;
  logic x_ld1, y_ld1, x_sel1, y_sel1, d_o_ld1, enable1, done1, err1;
  logic [7:0] iter0, iter1;
  logic [7:0] xr0, yr0, dr0, xr1, yr1, dr1;
  logic       lt0, neq0, lt1, neq1;

  int checks = 0;
  int errors = 0;
  int subx_n[2], suby_n[2], dold_n[2], both_n[2];

  always #5 clk = ~clk;

  assign lt0  = xr0 < yr0;
  assign neq0 = xr0 != yr0;
  assign lt1  = xr1 < yr1;
  assign neq1 = xr1 != yr1;

  gcd_controller dut0 (
    .clk(clk), .reset(reset), .go(go0), .x_lt_y(lt0), .x_neq_y(neq0),
    .x_ld(x_ld0), .y_ld(y_ld0), .x_sel(x_sel0), .y_sel(y_sel0), .d_o_ld(d_o_ld0),
    .enable(enable0), .done(done0), .err(err0), .iter_cnt(iter0)
  );

  gcd_controller #(.ITER_W(8), .MAX_ITER(4)) dut1 (
    .clk(clk), .reset(reset), .go(go1), .x_lt_y(lt1), .x_neq_y(neq1),
    .x_ld(x_ld1), .y_ld(y_ld1), .x_sel(x_sel1), .y_sel(y_sel1), .d_o_ld(d_o_ld1),
    .enable(enable1), .done(done1), .err(err1), .iter_cnt(iter1)
  );

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      xr0 <= '0; yr0 <= '0; dr0 <= '0;
      xr1 <= '0; yr1 <= '0; dr1 <= '0;
    end else begin
      if (x_ld0)   xr0 <= x_sel0 ? xr0 - yr0 : x_i;
      if (y_ld0)   yr0 <= y_sel0 ? yr0 - xr0 : y_i;
      if (d_o_ld0) dr0 <= xr0;
      if (x_ld1)   xr1 <= x_sel1 ? xr1 - yr1 : x_i;
      if (y_ld1)   yr1 <= y_sel1 ? yr1 - xr1 : y_i;
      if (d_o_ld1) dr1 <= xr1;
    end
  end

  // Strobe activity counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (x_ld0 && x_sel0)  subx_n[0] <= subx_n[0] + 1;
    if (y_ld0 && y_sel0)  suby_n[0] <= suby_n[0] + 1;
    if (d_o_ld0)          dold_n[0] <= dold_n[0] + 1;
    if (x_ld0 && y_ld0)   both_n[0] <= both_n[0] + 1;
    if (x_ld1 && x_sel1)  subx_n[1] <= subx_n[1] + 1;
    if (y_ld1 && y_sel1)  suby_n[1] <= suby_n[1] + 1;
    if (d_o_ld1)          dold_n[1] <= dold_n[1] + 1;
    if (x_ld1 && y_ld1)   both_n[1] <= both_n[1] + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] outs(input int inst);
    if (inst == 0) return {x_ld0, y_ld0, x_sel0, y_sel0, d_o_ld0, enable0, done0, err0};
    return {x_ld1, y_ld1, x_sel1, y_sel1, d_o_ld1, enable1, done1, err1};
  endfunction

  int s_subx, s_suby, s_dold, s_both;

  task automatic snap(input int inst);
    s_subx = subx_n[inst];
    s_suby = suby_n[inst];
    s_dold = dold_n[inst];
    s_both = both_n[inst];
  endtask

  // Starts a run; lat = edges after E at which done is first seen (E = first edge with go high).
  task automatic run(input int inst, input logic [7:0] x, input logic [7:0] y,
                     input int drop_at, output int lat);
    logic [7:0] o;
    lat = -1;
    x_i = x;
    y_i = y;
    snap(inst);
    if (inst == 0) go0 = 1'b1; else go1 = 1'b1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      o = outs(inst);
      if (k == 0) check("load_first_edge", {30'd0, o[7], o[6]}, 32'd3);
      if (o[1]) begin
        lat = k;
        break;
      end
      if (k == drop_at) begin
        if (inst == 0) go0 = 1'b0; else go1 = 1'b0;
      end
    end
    if (lat < 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_cycle(input int inst);
    if (inst == 0) go0 = 1'b0; else go1 = 1'b0;
    @(posedge clk); #1;
  endtask

  int lat;

  initial begin
    for (int i = 0; i < 2; i++) begin
      subx_n[i] = 0; suby_n[i] = 0; dold_n[i] = 0; both_n[i] = 0;
    end
    reset = 1'b0;
    go0 = 1'b1;
    go1 = 1'b1;
    x_i = 8'd3;
    y_i = 8'd7;

    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      x_i = x_i + 8'd5;
      y_i = y_i ^ 8'h0f;
      check("rst_outs0", {24'd0, outs(0)}, 32'd0);
      check("rst_outs1", {24'd0, outs(1)}, 32'd0);
      check("rst_iter0", {24'd0, iter0}, 32'd0);
    end
    go1 = 1'b0;

    // Release with go already high: first edge must load; 12,8 -> 4 in 2 subtractions.
    reset = 1'b1;
    run(0, 8'd12, 8'd8, -1, lat);
    check("lat_12_8", lat, 32'd7);
    check("do_12_8", {24'd0, dr0}, 32'd4);
    check("iter_12_8", {24'd0, iter0}, 32'd2);
    check("err_12_8", {31'd0, err0}, 32'd0);
    check("en_12_8", {31'd0, enable0}, 32'd1);
    check("subx_12_8", subx_n[0] - s_subx, 32'd1);
    check("suby_12_8", suby_n[0] - s_suby, 32'd1);
    check("dold_12_8", dold_n[0] - s_dold, 32'd1);
    check("both_12_8", both_n[0] - s_both, 32'd1);

    // go held high: no restart.
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_done", {31'd0, done0}, 32'd1);
    check("hold_noload", both_n[0] - s_both, 32'd1);
    idle_cycle(0);
    check("drop_done", {31'd0, done0}, 32'd0);
    check("iter_held_idle", {24'd0, iter0}, 32'd2);

    run(0, 8'd9, 8'd9, -1, lat);
    check("lat_9_9", lat, 32'd3);
    check("do_9_9", {24'd0, dr0}, 32'd9);
    check("iter_9_9", {24'd0, iter0}, 32'd0);
    check("dold_9_9", dold_n[0] - s_dold, 32'd1);
    check("subs_9_9", (subx_n[0] - s_subx) + (suby_n[0] - s_suby), 32'd0);
    idle_cycle(0);

    // go dropped while in CMP; 35,14 -> 7 in 3 subtractions.
    run(0, 8'd35, 8'd14, 1, lat);
    check("lat_35_14", lat, 32'd9);
    check("do_35_14", {24'd0, dr0}, 32'd7);
    check("iter_35_14", {24'd0, iter0}, 32'd3);
    check("both_35_14", both_n[0] - s_both, 32'd1);
    @(posedge clk); #1;
    check("auto_idle", {31'd0, done0}, 32'd0);
    check("iter_after_idle", {24'd0, iter0}, 32'd3);

    // MAX_ITER=4 instance: normal run then zero operand.
    run(1, 8'd6, 8'd4, -1, lat);
    check("lat_6_4", lat, 32'd7);
    check("do_6_4", {24'd0, dr1}, 32'd2);
    idle_cycle(1);
    run(1, 8'd0, 8'd5, -1, lat);
    check("lat_zero", lat, 32'd10);
    check("err_zero", {31'd0, err1}, 32'd1);
    check("en_zero", {31'd0, enable1}, 32'd0);
    check("iter_zero", {24'd0, iter1}, 32'd4);
    check("suby_zero", suby_n[1] - s_suby, 32'd4);
    check("dold_zero", dold_n[1] - s_dold, 32'd0);
    check("do_unchanged", {24'd0, dr1}, 32'd2);
    idle_cycle(1);
    check("err_clear", {30'd0, done1, err1}, 32'd0);

    // Asynchronous reset in the middle of SUBX.
    x_i = 8'd12;
    y_i = 8'd8;
    go0 = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("in_subx", {30'd0, x_ld0, x_sel0}, 32'd3);
    #2 reset = 1'b0;
    go0 = 1'b0;
    #1;
    check("async_outs", {24'd0, outs(0)}, 32'd0);
    check("async_iter", {24'd0, iter0}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("post_rst_idle", {24'd0, outs(0)}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
